decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 67 ++++++
 rtl/decode_core.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the 9-bit accumulator ISA decode stage: opcodes, ALU ops and the decoded bundle.
package decode_pkg;

    localparam int NUM_REGS_DEF = 12;
    localparam int REG_ADDR_W   = $clog2(NUM_REGS_DEF);
    localparam int INSTR_W      = 9;
    localparam int DATA_W       = 8;
    localparam int ALU_OP_W     = 4;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_MEM   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_ADDI  = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_TR    = 3'd5;
    localparam logic [2:0] OP_JR    = 3'd6;
    localparam logic [2:0] OP_SHIFT = 3'd7;

    localparam logic [1:0] SUB_AND  = 2'd0;
    localparam logic [1:0] SUB_SLT  = 2'd1;
    localparam logic [1:0] SUB_OR   = 2'd2;
    localparam logic [1:0] SUB_BEQ  = 2'd3;
    localparam logic [1:0] SUB_LW   = 2'd0;
    localparam logic [1:0] SUB_SW   = 2'd1;
    localparam logic [1:0] SUB_INC  = 2'd2;
    localparam logic [1:0] SUB_CLR  = 2'd3;
    localparam logic [1:0] SUB_SRL  = 2'd0;
    localparam logic [1:0] SUB_SRA  = 2'd1;
    localparam logic [1:0] SUB_SLL  = 2'd2;
    localparam logic [1:0] SUB_HALT = 2'd3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND  = 4'd0,
        ALU_SLT  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_PASS = 4'd6,
        ALU_BEQ  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLL  = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e                alu_op;
        logic [REG_ADDR_W-1:0]  rs_addr;
        logic [REG_ADDR_W-1:0]  rt_addr;
        logic [REG_ADDR_W-1:0]  rd_addr;
        logic [DATA_W-1:0]      imm;
        logic                   reg_clear;
        logic                   reg_write;
        logic                   car_write;
        logic                   sel_imm;
        logic                   jump;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem2reg;
        logic                   uses_rs;
        logic                   uses_rt;
    } decode_bundle_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[8:6] == OP_SHIFT) && (instr[1:0] == SUB_HALT);
    endfunction

endpackage

// File: rtl/decode_core.sv
// Pure combinational instruction decoder; every unused field is driven to 0.
module decode_core
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output decode_bundle_t     bundle_o
);

    logic [2:0]            op;
    logic [1:0]            sub;
    logic [REG_ADDR_W-1:0] f54, f32, f10, f52, f20, f53;

    assign op  = instr_i[8:6];
    assign sub = instr_i[1:0];
    assign f54 = REG_ADDR_W'(instr_i[5:4]);
    assign f32 = REG_ADDR_W'(instr_i[3:2]);
    assign f10 = REG_ADDR_W'(instr_i[1:0]);
    assign f52 = REG_ADDR_W'(instr_i[5:2]);
    assign f20 = REG_ADDR_W'(instr_i[2:0]);
    assign f53 = REG_ADDR_W'(instr_i[5:3]);

    // Register-index offsets wrap modulo 2^REG_ADDR_W by construction.
    always_comb begin
        bundle_o = '0;
        case (op)
            OP_RTYPE: begin
                bundle_o.uses_rs = 1'b1;
                bundle_o.uses_rt = 1'b1;
                if (sub == SUB_BEQ) begin
                    bundle_o.alu_op  = ALU_BEQ;
                    bundle_o.rs_addr = f54;
                    bundle_o.rt_addr = f32 + REG_ADDR_W'(8);
                end else begin
                    bundle_o.alu_op    = (sub == SUB_AND) ? ALU_AND :
                                         (sub == SUB_SLT) ? ALU_SLT : ALU_OR;
                    bundle_o.rs_addr   = f54 + REG_ADDR_W'(4);
                    bundle_o.rt_addr   = f32;
                    bundle_o.rd_addr   = REG_ADDR_W'(12);
                    bundle_o.reg_write = 1'b1;
                end
            end
            OP_MEM: begin
                case (sub)
                    SUB_LW: begin
                        bundle_o.alu_op    = ALU_PASS;
                        bundle_o.rs_addr   = f54 + REG_ADDR_W'(4);
                        bundle_o.rd_addr   = f32;
                        bundle_o.reg_write = 1'b1;
                        bundle_o.mem_read  = 1'b1;
                        bundle_o.mem2reg   = 1'b1;
                        bundle_o.uses_rs   = 1'b1;
                    end
                    SUB_SW: begin
                        bundle_o.alu_op    = ALU_PASS;
                        bundle_o.rs_addr   = f54 + REG_ADDR_W'(4);
                        bundle_o.rt_addr   = f32;
                        bundle_o.mem_write = 1'b1;
                        bundle_o.uses_rs   = 1'b1;
                        bundle_o.uses_rt   = 1'b1;
                    end
                    SUB_INC: begin
                        bundle_o.alu_op    = ALU_ADD;
                        bundle_o.rs_addr   = f52;
                        bundle_o.rd_addr   = f52;
                        bundle_o.imm       = DATA_W'(1);
                        bundle_o.sel_imm   = 1'b1;
                        bundle_o.reg_write = 1'b1;
                        bundle_o.uses_rs   = 1'b1;
                    end
                    SUB_CLR: begin
                        bundle_o.rd_addr   = f52;
                        bundle_o.reg_clear = 1'b1;
                        bundle_o.reg_write = 1'b1;
                    end
                endcase
            end
            OP_ADD, OP_SUB: begin
                bundle_o.alu_op    = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
                bundle_o.rs_addr   = f54 + REG_ADDR_W'(4);
                bundle_o.rt_addr   = f32;
                bundle_o.rd_addr   = f10 + REG_ADDR_W'(8);
                bundle_o.reg_write = 1'b1;
                bundle_o.car_write = 1'b1;
                bundle_o.uses_rs   = 1'b1;
                bundle_o.uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                bundle_o.alu_op    = ALU_ADD;
                bundle_o.rs_addr   = f32;
                bundle_o.rd_addr   = f54 + REG_ADDR_W'(8);
                bundle_o.imm       = DATA_W'(instr_i[1:0]);
                bundle_o.sel_imm   = 1'b1;
                bundle_o.reg_write = 1'b1;
                bundle_o.uses_rs   = 1'b1;
            end
            OP_TR: begin
                bundle_o.alu_op    = ALU_PASS;
                bundle_o.rs_addr   = f20 + REG_ADDR_W'(5);
                bundle_o.rd_addr   = f53 + REG_ADDR_W'(1);
                bundle_o.reg_write = 1'b1;
                bundle_o.uses_rs   = 1'b1;
            end
            OP_JR: begin
                bundle_o.alu_op = ALU_PASS;
                bundle_o.imm    = DATA_W'(instr_i[5:0]);
                bundle_o.jump   = 1'b1;
            end
            OP_SHIFT: begin
                if (sub != SUB_HALT) begin
                    bundle_o.alu_op    = (sub == SUB_SRL) ? ALU_SRL :
                                         (sub == SUB_SRA) ? ALU_SRA : ALU_SLL;
                    bundle_o.rs_addr   = f54 + REG_ADDR_W'(4);
                    bundle_o.rd_addr   = f54 + REG_ADDR_W'(4);
                    bundle_o.rt_addr   = f32;
                    bundle_o.reg_write = 1'b1;
                    bundle_o.car_write = 1'b1;
                    bundle_o.uses_rs   = 1'b1;
                    bundle_o.uses_rt   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, flush, sticky halt and bubble counter.
// Optional load-use interlock is enabled by defining DECODE_LOAD_USE_INTERLOCK_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_REGS    = 12,
    parameter int INSTR_WIDTH = 9,
    parameter int REG_WIDTH   = 8,
    parameter int OP_WIDTH    = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int RA_W       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [RA_W-1:0]        rs_addr,
    output logic [RA_W-1:0]        rt_addr,
    output logic [RA_W-1:0]        rd_addr,
    output logic [REG_WIDTH-1:0]   imm,
    output logic                   reg_clear,
    output logic                   reg_write,
    output logic                   car_write,
    output logic                   sel_imm,
    output logic                   jump,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem2reg,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   bubble_count
);

    decode_bundle_t        core_b, bundle_q, bundle_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  bub_q, bub_d;
    logic                  stall, accept;

    decode_core u_core (
        .instr_i  (instruction),
        .bundle_o (core_b)
    );

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    logic                  lp_q, lp_d;
    logic [RA_W-1:0]       lrd_q, lrd_d;

    // Stall only in the single cycle after an LW leaves, and only on a real source match.
    assign stall = lp_q && in_valid &&
                   ((core_b.uses_rs && (core_b.rs_addr == lrd_q)) ||
                    (core_b.uses_rt && (core_b.rt_addr == lrd_q)));
    assign lp_d  = !flush && valid_q && out_ready && bundle_q.mem_read;
    assign lrd_d = bundle_q.rd_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lp_q  <= 1'b0;
            lrd_q <= '0;
        end else begin
            lp_q  <= lp_d;
            lrd_q <= lrd_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign in_ready = !halted_q && !stall && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = core_b;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        halted_d = halted_q || (accept && !flush && is_halt(instruction));
        bub_d    = (stall && (bub_q != '1)) ? bub_q + 1'b1 : bub_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            halted_q <= 1'b0;
            bub_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            halted_q <= halted_d;
            bub_q    <= bub_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_op       = bundle_q.alu_op;
    assign rs_addr      = bundle_q.rs_addr;
    assign rt_addr      = bundle_q.rt_addr;
    assign rd_addr      = bundle_q.rd_addr;
    assign imm          = bundle_q.imm;
    assign reg_clear    = bundle_q.reg_clear;
    assign reg_write    = bundle_q.reg_write;
    assign car_write    = bundle_q.car_write;
    assign sel_imm      = bundle_q.sel_imm;
    assign jump         = bundle_q.jump;
    assign mem_read     = bundle_q.mem_read;
    assign mem_write    = bundle_q.mem_write;
    assign mem2reg      = bundle_q.mem2reg;
    assign halted       = halted_q;
    assign bubble_count = bub_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, handshake sequences, decoder sweep, random vs model.
module tb_decode_stage;
    import decode_pkg::*;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    localparam logic [7:0] C_CLR = 8'h80, C_RW = 8'h40, C_CW = 8'h20, C_SEL = 8'h10;
    localparam logic [7:0] C_JMP = 8'h08, C_MR = 8'h04, C_MW = 8'h02, C_M2R = 8'h01;
    localparam logic [8:0] I_HALT = 9'b111_000_011;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] imm;
        logic [7:0] ctl;
    } exp_t;

    typedef struct {
        logic [8:0] instr;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [8:0]  instruction = '0;
    logic [3:0]  alu_op, rs_addr, rt_addr, rd_addr;
    logic [7:0]  imm;
    logic        reg_clear, reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg;
    logic        halted;
    logic [15:0] bubble_count;

    logic [8:0]     sw_instr = '0;
    decode_bundle_t sw_b;
    exp_t           act, sw_act;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
        .reg_clear(reg_clear), .reg_write(reg_write), .car_write(car_write), .sel_imm(sel_imm),
        .jump(jump), .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
        .halted(halted), .bubble_count(bubble_count)
    );

    decode_core u_sweep (.instr_i(sw_instr), .bundle_o(sw_b));

    assign act = {alu_op, rs_addr, rt_addr, rd_addr, imm,
                  reg_clear, reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg};
    assign sw_act = {sw_b.alu_op, sw_b.rs_addr, sw_b.rt_addr, sw_b.rd_addr, sw_b.imm,
                     sw_b.reg_clear, sw_b.reg_write, sw_b.car_write, sw_b.sel_imm, sw_b.jump,
                     sw_b.mem_read, sw_b.mem_write, sw_b.mem2reg};

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic logic [3:0] m16(input int v);
        return 4'(v % 16);
    endfunction

    // Reference decode written straight from the instruction map using integer arithmetic.
    function automatic exp_t golden(input logic [8:0] i);
        exp_t e;
        int op, s, a, b;
        e  = '0;
        op = int'(i[8:6]);
        s  = int'(i[1:0]);
        a  = int'(i[5:4]);
        b  = int'(i[3:2]);
        case (op)
            0: if (s < 3) begin
                   e.alu = m16(s); e.rs = m16(a + 4); e.rt = m16(b); e.rd = m16(12); e.ctl = C_RW;
               end else begin
                   e.alu = m16(7); e.rs = m16(a); e.rt = m16(b + 8);
               end
            1: case (s)
                   0: begin e.alu = m16(6); e.rs = m16(a + 4); e.rd = m16(b); e.ctl = C_RW | C_MR | C_M2R; end
                   1: begin e.alu = m16(6); e.rs = m16(a + 4); e.rt = m16(b); e.ctl = C_MW; end
                   2: begin e.alu = m16(4); e.rs = m16(int'(i[5:2])); e.rd = e.rs; e.imm = 8'd1; e.ctl = C_SEL | C_RW; end
                   default: begin e.rd = m16(int'(i[5:2])); e.ctl = C_CLR | C_RW; end
               endcase
            2, 4: begin
                e.alu = m16(op == 2 ? 4 : 5); e.rs = m16(a + 4); e.rt = m16(b); e.rd = m16(s + 8);
                e.ctl = C_RW | C_CW;
            end
            3: begin e.alu = m16(4); e.rs = m16(b); e.rd = m16(a + 8); e.imm = 8'(s); e.ctl = C_SEL | C_RW; end
            5: begin e.alu = m16(6); e.rs = m16(int'(i[2:0]) + 5); e.rd = m16(int'(i[5:3]) + 1); e.ctl = C_RW; end
            6: begin e.alu = m16(6); e.imm = 8'(i[5:0]); e.ctl = C_JMP; end
            default: if (s < 3) begin
                e.alu = m16(8 + s); e.rs = m16(a + 4); e.rd = e.rs; e.rt = m16(b); e.ctl = C_RW | C_CW;
            end
        endcase
        return e;
    endfunction

    function automatic bit is_halt_i(input logic [8:0] i);
        return (i[8:6] == 3'd7) && (i[1:0] == 2'd3);
    endfunction

    function automatic bit uses_rs(input logic [8:0] i);
        return !((i[8:6] == 3'd6) || (i[8:6] == 3'd1 && i[1:0] == 2'd3) || is_halt_i(i));
    endfunction

    function automatic bit uses_rt(input logic [8:0] i);
        return (i[8:6] == 3'd0) || (i[8:6] == 3'd2) || (i[8:6] == 3'd4) ||
               (i[8:6] == 3'd1 && i[1:0] == 2'd1) || (i[8:6] == 3'd7 && i[1:0] != 2'd3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instruction = '0;
        reset_n = 1'b0;
        #7;
        reset_n = 1'b1;
        tick();
    endtask

    vec_t tab[13];
    exp_t g, gh;
    bit   m_valid, m_halt, m_lp, st, ir, acc;
    logic [8:0]  m_instr, ins;
    logic [3:0]  m_lrd;
    logic [15:0] m_bub;

    initial begin
        tab[0]  = '{9'b010_01_10_11, {4'd4,  4'd5,  4'd2, 4'd11, 8'h00, 8'h60}};
        tab[1]  = '{9'b000_11_01_00, {4'd0,  4'd7,  4'd1, 4'd12, 8'h00, 8'h40}};
        tab[2]  = '{9'b000_10_11_11, {4'd7,  4'd2,  4'd11, 4'd0, 8'h00, 8'h00}};
        tab[3]  = '{9'b001_00_10_00, {4'd6,  4'd4,  4'd0, 4'd2,  8'h00, 8'h45}};
        tab[4]  = '{9'b001_11_01_01, {4'd6,  4'd7,  4'd1, 4'd0,  8'h00, 8'h02}};
        tab[5]  = '{9'b001_1011_10,  {4'd4,  4'd11, 4'd0, 4'd11, 8'h01, 8'h50}};
        tab[6]  = '{9'b001_0110_11,  {4'd0,  4'd0,  4'd0, 4'd6,  8'h00, 8'hC0}};
        tab[7]  = '{9'b011_11_01_10, {4'd4,  4'd1,  4'd0, 4'd11, 8'h02, 8'h50}};
        tab[8]  = '{9'b101_111_111,  {4'd6,  4'd12, 4'd0, 4'd8,  8'h00, 8'h40}};
        tab[9]  = '{9'b110_101010,   {4'd6,  4'd0,  4'd0, 4'd0,  8'h2A, 8'h08}};
        tab[10] = '{9'b100_11_11_11, {4'd5,  4'd7,  4'd3, 4'd11, 8'h00, 8'h60}};
        tab[11] = '{9'b111_10_00_01, {4'd9,  4'd6,  4'd0, 4'd6,  8'h00, 8'h60}};
        tab[12] = '{9'b111_00_11_10, {4'd10, 4'd4,  4'd3, 4'd4,  8'h00, 8'h60}};

        // Reset state, then async reset with a held HALT bundle.
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fields", 64'(act), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_bubble", 64'(bubble_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0; in_valid = 1'b1; instruction = I_HALT;
        tick();
        in_valid = 1'b0;
        chk("halt_held_valid", 64'(out_valid), 64'd1);
        chk("halt_held_halted", 64'(halted), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_halted", 64'(halted), 64'd0);
        chk("async_rst_fields", 64'(act), 64'd0);
        #3;
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Decode table, back-to-back accepts with out_ready high.
        do_reset();
        for (int k = 0; k < 13; k++) begin
            in_valid = 1'b1; instruction = tab[k].instr;
            tick();
            chk("tab_valid", 64'(out_valid), 64'd1);
            chk($sformatf("tab_fields_%0d", k), 64'(act), 64'(tab[k].e));
        end
        in_valid = 1'b0;
        tick();
        chk("tab_drain", 64'(out_valid), 64'd0);

        // Backpressure: bundle frozen, in_ready low, then transfer plus accept in one cycle.
        do_reset();
        in_valid = 1'b1; instruction = 9'b010_01_10_11;
        tick();
        out_ready = 1'b0; instruction = 9'b100_11_11_11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_frozen", 64'(act), 64'(golden(9'b010_01_10_11)));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_fields", 64'(act), 64'(golden(9'b100_11_11_11)));
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Flush beats a HALT accept; then a real HALT locks the stage.
        do_reset();
        in_valid = 1'b1; instruction = I_HALT; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_halt_valid", 64'(out_valid), 64'd0);
        chk("flush_halt_halted", 64'(halted), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("halt_valid", 64'(out_valid), 64'd1);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_fields", 64'(act), 64'd0);
        in_valid = 1'b1; instruction = 9'b010_01_10_11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("halt_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("halt_stuck_valid", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
        // Load-use: dependent ADD waits one cycle, independent ADD goes straight in.
        do_reset();
        in_valid = 1'b1; instruction = 9'b001_00_10_00;
        tick();
        in_valid = 1'b0;
        chk("lu_lw_valid", 64'(out_valid), 64'd1);
        tick();
        in_valid = 1'b1; instruction = 9'b010_00_10_00;
        #1;
        chk("lu_stall", 64'(in_ready), 64'd0);
        tick();
        chk("lu_bubble", 64'(bubble_count), 64'd1);
        chk("lu_retry_ready", 64'(in_ready), 64'd1);
        tick();
        chk("lu_add_fields", 64'(act), 64'(golden(9'b010_00_10_00)));
        instruction = 9'b001_00_10_00;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; instruction = 9'b010_00_01_00;
        #1;
        chk("lu_indep_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("lu_indep_bubble", 64'(bubble_count), 64'd1);
`endif

        // Exhaustive decoder sweep.
        for (int v = 0; v < 512; v++) begin
            sw_instr = 9'(v);
            #1;
            chk($sformatf("sweep_%0h", v), 64'(sw_act), 64'(golden(9'(v))));
            chk("sweep_uses", 64'({sw_b.uses_rs, sw_b.uses_rt}), 64'({uses_rs(9'(v)), uses_rt(9'(v))}));
            chk("sweep_x", 64'($isunknown(sw_b)), 64'd0);
        end

        // Random traffic against a cycle-level model of the handshake rules.
        do_reset();
        m_valid = 0; m_halt = 0; m_lp = 0; m_instr = '0; m_lrd = '0; m_bub = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ins = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) ins = {3'b001, 4'($urandom_range(0, 15)), 2'b00};
            if (is_halt_i(ins)) ins = 9'b010_00_00_00;
            instruction = ins;
            #1;
            g  = golden(ins);
            st = IL && m_lp && in_valid &&
                 ((uses_rs(ins) && g.rs == m_lrd) || (uses_rt(ins) && g.rt == m_lrd));
            ir = !m_halt && !st && (!m_valid || out_ready);
            chk("rnd_in_ready", 64'(in_ready), 64'(ir));
            chk("rnd_out_valid", 64'(out_valid), 64'(m_valid));
            chk("rnd_bubble", 64'(bubble_count), 64'(m_bub));
            if (m_valid) chk("rnd_fields", 64'(act), 64'(golden(m_instr)));
            acc = in_valid && ir;
            gh  = golden(m_instr);
            if (st && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
            m_lp  = !flush && m_valid && out_ready && gh.ctl[2];
            m_lrd = gh.rd;
            if (flush) m_valid = 0;
            else if (acc) begin m_valid = 1; m_instr = ins; end
            else if (out_ready) m_valid = 0;
            tick();
        end
        chk("rnd_halted", 64'(halted), 64'(m_halt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
